ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset).
- Complements the existing keyboard receive path and shares the same open-drain ps2_clock/ps2_data lines.
- Runs on fpga_clock. The device clock is oversampled through synchronizers.
- Outputs are drive-low enables; the top level builds the open-drain pads.

Parameters:
- INHIBIT_CYCLES, 10000: fpga_clock cycles the host holds the clock low before the start bit (100 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum fpga_clock cycles between device clock falling edges before the frame is aborted (20 ms).
- TIMER_W, 24: width of the shared inhibit/timeout counter. It must hold both counts.

Ports:
- fpga_clock  in  1  system clock
- reset  in  1  asynchronous, active-low
- tx_valid  in  1  request to send tx_data
- tx_data  in  8  command byte; sampled when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- ps2_clk_in  in  1  raw PS/2 clock pad input
- ps2_data_in  in  1  raw PS/2 data pad input
- ps2_clk_drive_low  out  1  1 = pull PS/2 clock low, 0 = release
- ps2_data_drive_low  out  1  1 = pull PS/2 data low, 0 = release
- tx_done  out  1  one-cycle pulse: frame sent and acknowledged
- tx_error  out  1  one-cycle pulse: NACK or timeout

Behaviour:
- Reset (async, active-low):
  - State is IDLE; both drive_low outputs are 0.
  - tx_done=0, tx_error=0, tx_ready=1.
  - Synchronizer flops preset to 1.
- Input conditioning:
  - Two-flop synchronizer on each pad input.
  - A falling edge (fe) is sync_prev=1 and sync_now=0 on ps2 clock.
  - Drive outputs are registered, so they change on the cycle after fe is detected.
- Accept: tx_valid && tx_ready in IDLE latches the shift register and computes odd parity (~^tx_data). tx_valid is ignored in every other state.
- States:
  - IDLE -> INHIBIT on accept.
  - INHIBIT: clk_drive_low=1, data_drive_low=0, for exactly INHIBIT_CYCLES cycles.
  - INHIBIT -> START: data_drive_low=1 and clk_drive_low=1 for 1 cycle.
  - START -> SEND: clk_drive_low=0 and data_drive_low=1 (start bit). Bit counter = 0; timer cleared.
  - SEND, on each fe:
    - Counter 0..7: drive data bit[counter], LSB first. data_drive_low = ~bit.
    - Counter 8: drive parity.
    - Counter 9: release data (stop bit = 1), go to ACK.
    - The counter increments on each fe.
  - ACK: on the next fe, sample synchronized data. 0 = ACK, 1 = NACK. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synchronized clock and data are both 1, then return to IDLE. On that cycle, pulse tx_done (ACK) or tx_error (NACK).
- Timeout:
  - Applies in SEND, ACK and WAIT_IDLE. The timer resets on every fe.
  - When the timer reaches TIMEOUT_CYCLES: release both lines, pulse tx_error, go to IDLE.
- Timer: one TIMER_W counter reused for INHIBIT and timeout. It saturates and never wraps.
- Simultaneous events:
  - Timeout and fe in the same cycle: fe wins and the timer clears.
  - tx_done and tx_error are never high together.
- Reset mid-frame: lines release asynchronously and no pulse is generated.
- The receive path sees the host-driven bits on the shared lines. Gating that is the top level's responsibility.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined:
  - On the first NACK or timeout of a frame, release lines for one cycle and restart at INHIBIT with the same latched byte. No tx_error pulse on this first failure.
  - A second failure pulses tx_error. A success on retry pulses tx_done.
  - Retry flag clears on return to IDLE.
- Undefined: the first failure pulses tx_error immediately; no retry logic is synthesized.

Test Plan (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200; behavioural device generates clock at 40 cycles/half-period):
- Send 0xED, device ACKs.
  - Clock held low exactly 20 cycles, then data low.
  - Device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once; tx_ready returns to 1.
- Send 0x01, device ACKs: parity bit sampled as 0; tx_done pulses.
- Send 0x00, device leaves data high at ACK clock: tx_error pulses (macro undefined); no tx_done.
- Send 0x55, device never clocks: 200 cycles after START, both drive_low outputs go to 0, tx_error pulses, tx_ready=1.
- Assert reset after the 4th fe of a 0xF0 frame: both drive_low outputs go to 0 immediately; after release, tx_ready=1 and no pulses.
- Hold tx_valid with 0xAA during a 0xED frame: only 0xED is transmitted. With PS2_HOST_TX_RETRY_EN and the first frame NACKed, a second 0xED frame follows and tx_done pulses.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start bit, 8 data bits, odd parity, stop, ACK.
// Optional macro PS2_HOST_TX_RETRY_EN re-sends the latched byte once after a NACK or timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int TIMER_W        = 24
) (
    input  logic       fpga_clock,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       tx_done,
    output logic       tx_error
);
    typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE, RETRY} state_t;

    localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX    = '1;

    logic clk_meta, clk_sync, clk_prev, data_meta, data_sync;
    logic fe, lines_idle;

    // Idle-high lines, so the synchronizers come out of reset at 1 and see no false edge.
    always_ff @(posedge fpga_clock or negedge reset) begin
        if (!reset) begin
            {clk_meta, clk_sync, clk_prev, data_meta, data_sync} <= '1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign fe         = clk_prev & ~clk_sync;
    assign lines_idle = clk_sync & data_sync;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [3:0]         bit_cnt;
    logic [7:0]         tx_byte;
    logic               parity, ack_ok;
    logic               timing, timeout, nack, fail;
`ifdef PS2_HOST_TX_RETRY_EN
    logic               retried;
`endif

    assign timing   = state inside {SEND, ACK, WAIT_IDLE};
    // A device edge in the same cycle as expiry keeps the frame alive.
    assign timeout  = timing && !fe && (timer >= TIMEOUT_LAST);
    assign nack     = (state == WAIT_IDLE) && lines_idle && !ack_ok;
    assign fail     = timeout | nack;
    assign tx_ready = (state == IDLE);

    always_ff @(posedge fpga_clock or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            timer              <= '0;
            bit_cnt            <= '0;
            tx_byte            <= '0;
            parity             <= 1'b0;
            ack_ok             <= 1'b0;
            ps2_clk_drive_low  <= 1'b0;
            ps2_data_drive_low <= 1'b0;
            tx_done            <= 1'b0;
            tx_error           <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retried            <= 1'b0;
`endif
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (timing) begin
                if (fe)
                    timer <= '0;
                else if (timer != TIMER_MAX)
                    timer <= timer + 1'b1;
            end
            if (fail) begin
                ps2_clk_drive_low  <= 1'b0;
                ps2_data_drive_low <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
                if (!retried) begin
                    retried <= 1'b1;
                    state   <= RETRY;
                end else begin
                    tx_error <= 1'b1;
                    state    <= IDLE;
                end
`else
                tx_error <= 1'b1;
                state    <= IDLE;
`endif
            end else begin
                case (state)
                    IDLE: begin
`ifdef PS2_HOST_TX_RETRY_EN
                        retried <= 1'b0;
`endif
                        if (tx_valid) begin
                            tx_byte            <= tx_data;
                            parity             <= ~^tx_data;
                            timer              <= '0;
                            ps2_clk_drive_low  <= 1'b1;
                            ps2_data_drive_low <= 1'b0;
                            state              <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (timer == INHIBIT_LAST) begin
                            ps2_data_drive_low <= 1'b1;
                            state              <= START;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    START: begin
                        ps2_clk_drive_low <= 1'b0;
                        bit_cnt           <= '0;
                        timer             <= '0;
                        state             <= SEND;
                    end
                    SEND: begin
                        if (fe) begin
                            if (bit_cnt < 4'd8)
                                ps2_data_drive_low <= ~tx_byte[bit_cnt[2:0]];
                            else if (bit_cnt == 4'd8)
                                ps2_data_drive_low <= ~parity;
                            else begin
                                ps2_data_drive_low <= 1'b0;
                                state              <= ACK;
                            end
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ACK: begin
                        if (fe) begin
                            ack_ok <= ~data_sync;
                            state  <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        // The NACK exit is taken by the fail path above.
                        if (lines_idle) begin
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end
                    end
`ifdef PS2_HOST_TX_RETRY_EN
                    RETRY: begin
                        ps2_clk_drive_low  <= 1'b1;
                        ps2_data_drive_low <= 1'b0;
                        timer              <= '0;
                        state              <= INHIBIT;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device (40-cycle clock half-periods).
module tb_ps2_host_tx;
    logic       fpga_clock = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready, ps2_clk_drive_low, ps2_data_drive_low, tx_done, tx_error;
    logic       dev_clk, dev_data;
    logic       clk_line, data_line;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;

    assign clk_line  = dev_clk & ~ps2_clk_drive_low;
    assign data_line = dev_data & ~ps2_data_drive_low;

    always #5 fpga_clock = ~fpga_clock;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(200), .TIMER_W(24)) dut (
        .fpga_clock        (fpga_clock),
        .reset             (reset),
        .tx_valid          (tx_valid),
        .tx_data           (tx_data),
        .tx_ready          (tx_ready),
        .ps2_clk_in        (clk_line),
        .ps2_data_in       (data_line),
        .ps2_clk_drive_low (ps2_clk_drive_low),
        .ps2_data_drive_low(ps2_data_drive_low),
        .tx_done           (tx_done),
        .tx_error          (tx_error)
    );

    always @(posedge fpga_clock) begin
        if (tx_done)             done_cnt <= done_cnt + 1;
        if (tx_error)            err_cnt  <= err_cnt + 1;
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input logic [7:0] b);
        @(negedge fpga_clock);
        tx_valid = 1'b1;
        tx_data  = b;
    endtask

    // Counts clock-only inhibit cycles until the host releases clock with the start bit driven.
    task automatic wait_start(input bit hold, output int inh);
        bit ok;
        ok  = 1'b0;
        inh = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge fpga_clock);
            if (hold) tx_data = 8'hAA;
            else      tx_valid = 1'b0;
            if (!ps2_clk_drive_low && ps2_data_drive_low) begin
                ok = 1'b1;
                break;
            end
            if (ps2_clk_drive_low && !ps2_data_drive_low) inh++;
        end
        if (!ok) chk("start_seen", 0, 1);
    endtask

    task automatic dev_clock(output logic s);
        repeat (40) @(negedge fpga_clock);
        dev_clk = 1'b0;
        repeat (40) @(negedge fpga_clock);
        s = data_line;
        dev_clk = 1'b1;
    endtask

    task automatic dev_frame(input bit ack, output logic [9:0] bits);
        logic s;
        for (int i = 0; i < 10; i++) begin
            dev_clock(s);
            bits[i] = s;
        end
        if (ack) dev_data = 1'b0;
        dev_clock(s);
        tx_valid = 1'b0;
        repeat (5) @(negedge fpga_clock);
        dev_data = 1'b1;
    endtask

    task automatic count_timeout(output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge fpga_clock);
            n++;
            if (!ps2_data_drive_low) break;
        end
    endtask

    initial begin
        int         inh, n, d0, e0;
        logic [9:0] bits;
        logic       s;

        reset = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
        repeat (3) @(negedge fpga_clock);
        chk("rst_ready", tx_ready, 1);
        chk("rst_clk_dl", ps2_clk_drive_low, 0);
        chk("rst_data_dl", ps2_data_drive_low, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_error", tx_error, 0);
        reset = 1'b1;
        repeat (3) @(negedge fpga_clock);

        // 0xED acknowledged
        d0 = done_cnt; e0 = err_cnt;
        kick(8'hED);
        wait_start(1'b0, inh);
        chk("ed_inhibit", inh, 20);
        dev_frame(1'b1, bits);
        repeat (10) @(negedge fpga_clock);
        chk("ed_bits", bits, 10'h3ED);
        chk("ed_done", done_cnt - d0, 1);
        chk("ed_error", err_cnt - e0, 0);
        chk("ed_ready", tx_ready, 1);

        // 0x01 acknowledged, parity 0
        d0 = done_cnt; e0 = err_cnt;
        kick(8'h01);
        wait_start(1'b0, inh);
        dev_frame(1'b1, bits);
        repeat (10) @(negedge fpga_clock);
        chk("x01_bits", bits, 10'h201);
        chk("x01_done", done_cnt - d0, 1);
        chk("x01_error", err_cnt - e0, 0);

        // 0x00 NACKed
        d0 = done_cnt; e0 = err_cnt;
        kick(8'h00);
        wait_start(1'b0, inh);
        dev_frame(1'b0, bits);
`ifdef PS2_HOST_TX_RETRY_EN
        repeat (10) @(negedge fpga_clock);
        chk("nack_first_err", err_cnt - e0, 0);
        wait_start(1'b1, inh);
        dev_frame(1'b0, bits);
`endif
        repeat (10) @(negedge fpga_clock);
        chk("nack_bits", bits, 10'h300);
        chk("nack_error", err_cnt - e0, 1);
        chk("nack_done", done_cnt - d0, 0);

        // 0x55 with a silent device
        e0 = err_cnt;
        kick(8'h55);
        wait_start(1'b0, inh);
        count_timeout(n);
        chk("to_cycles", n, 200);
        chk("to_clk_dl", ps2_clk_drive_low, 0);
`ifdef PS2_HOST_TX_RETRY_EN
        chk("to_first_err", tx_error, 0);
        wait_start(1'b1, inh);
        count_timeout(n);
        chk("to_retry_cycles", n, 200);
`endif
        chk("to_error", tx_error, 1);
        chk("to_ready", tx_ready, 1);
        repeat (5) @(negedge fpga_clock);
        chk("to_error_once", err_cnt - e0, 1);

        // Reset after the 4th falling edge of 0xF0
        kick(8'hF0);
        wait_start(1'b0, inh);
        for (int i = 0; i < 3; i++) dev_clock(s);
        repeat (40) @(negedge fpga_clock);
        dev_clk = 1'b0;
        repeat (10) @(negedge fpga_clock);
        chk("rst_mid_data_bit3", ps2_data_drive_low, 1);
        d0 = done_cnt; e0 = err_cnt;
        reset = 1'b0;
        #1;
        chk("rst_mid_clk_dl", ps2_clk_drive_low, 0);
        chk("rst_mid_data_dl", ps2_data_drive_low, 0);
        dev_clk = 1'b1;
        repeat (5) @(negedge fpga_clock);
        reset = 1'b1;
        repeat (50) @(negedge fpga_clock);
        chk("rst_mid_ready", tx_ready, 1);
        chk("rst_mid_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        // tx_valid held with 0xAA during a 0xED frame
        d0 = done_cnt; e0 = err_cnt;
        kick(8'hED);
        wait_start(1'b1, inh);
        chk("hold_inhibit", inh, 20);
`ifdef PS2_HOST_TX_RETRY_EN
        dev_frame(1'b0, bits);
        chk("hold_first_bits", bits, 10'h3ED);
        wait_start(1'b1, inh);
`endif
        dev_frame(1'b1, bits);
        chk("hold_bits", bits, 10'h3ED);
        repeat (60) @(negedge fpga_clock);
        chk("hold_done", done_cnt - d0, 1);
        chk("hold_error", err_cnt - e0, 0);
        chk("hold_no_second", ps2_clk_drive_low, 0);
        chk("hold_ready", tx_ready, 1);
        chk("done_error_exclusive", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
